demux_rr_n: RTL and testbench

- Parametrised 1-to-N burst demultiplexer; next generation of the two-output alternating demux.
- A burst is a run of consecutive cycles with valid_in high. Each burst is routed to one output channel; successive bursts rotate round-robin over the enabled channels.
- Adds channel count, data width, per-channel enable mask, forced burst split at MAX_BURST, drop flag and registered outputs.
- Sits on the clk2f domain between the byte-striping/serial-to-parallel stage and the per-lane FIFOs.

---
 rtl/demux_rr_n.sv | 161 ++++++++++++++++
 tb/tb_demux_rr_n.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/demux_rr_n.sv
// 1-to-N round-robin burst demultiplexer with per-channel enable, forced split at MAX_BURST and drop flag.
// All outputs are registered (one cycle latency); there is no backpressure. DEMUX_RR_WORDCNT_EN adds words_routed.
module demux_rr_n #(
    parameter int DATA_W    = 8,
    parameter int N_CH      = 4,
    parameter int CH_W      = 2,
    parameter int MAX_BURST = 16,
    parameter int CNT_W     = 16
) (
    input  logic                   clk2f,
    input  logic                   reset,
    input  logic [DATA_W-1:0]      data_in,
    input  logic                   valid_in,
    input  logic [N_CH-1:0]        chan_en,
    output logic [N_CH*DATA_W-1:0] data_out,
    output logic [N_CH-1:0]        valid_out,
    output logic [CH_W-1:0]        cur_ch,
    output logic                   drop
`ifdef DEMUX_RR_WORDCNT_EN
    ,
    output logic [CNT_W-1:0]       words_routed
`endif
);

    localparam int BC_W = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

    if (CH_W != $clog2(N_CH)) begin : g_chw_chk
        $error("CH_W must equal clog2(N_CH)");
    end
    if (N_CH < 2 || N_CH > 16) begin : g_nch_chk
        $error("N_CH must be in 2..16");
    end
    if (CNT_W < 1) begin : g_cntw_chk
        $error("CNT_W must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRANS = 2'd1,
        WAIT  = 2'd2,
        DROP  = 2'd3
    } state_t;

    state_t                  state, state_nx;
    logic [BC_W-1:0]         burst_cnt, cnt_nx;
    logic [CH_W-1:0]         ch_nx, sel_ch;
    logic                    sel_found, route, drop_nx;
    logic [CH_W:0]           base_sh, sel_off;
    logic [CH_W+1:0]         sel_sum;
    logic [2*N_CH-1:0]       en_rot;
    logic [N_CH*DATA_W-1:0]  data_nx;
    logic [N_CH-1:0]         valid_nx;

    // Rotate a doubled copy of the mask so the scan always runs from bit 0 upward.
    always_comb begin
        base_sh   = (state == IDLE) ? '0 : ({1'b0, cur_ch} + 1'b1);
        en_rot    = {chan_en, chan_en} >> base_sh;
        sel_found = 1'b0;
        sel_off   = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (en_rot[k]) begin
                sel_found = 1'b1;
                sel_off   = (CH_W+1)'(k);
            end
        end
        sel_sum = {1'b0, base_sh} + {1'b0, sel_off};
        if (sel_sum >= (CH_W+2)'(N_CH)) begin
            sel_sum = sel_sum - (CH_W+2)'(N_CH);
        end
        sel_ch = sel_sum[CH_W-1:0];
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = burst_cnt;
        ch_nx    = cur_ch;
        route    = 1'b0;
        drop_nx  = 1'b0;
        case (state)
            IDLE, WAIT: begin
                if (valid_in) begin
                    if (sel_found) begin
                        route    = 1'b1;
                        ch_nx    = sel_ch;
                        cnt_nx   = BC_W'(1);
                        state_nx = TRANS;
                    end else begin
                        drop_nx  = 1'b1;
                        state_nx = DROP;
                    end
                end
            end
            TRANS: begin
                if (!valid_in) begin
                    cnt_nx   = '0;
                    state_nx = WAIT;
                end else if (MAX_BURST == 0 || int'(burst_cnt) < MAX_BURST) begin
                    route  = 1'b1;
                    cnt_nx = (MAX_BURST == 0) ? burst_cnt : burst_cnt + BC_W'(1);
                end else if (sel_found) begin
                    route  = 1'b1;
                    ch_nx  = sel_ch;
                    cnt_nx = BC_W'(1);
                end else begin
                    drop_nx  = 1'b1;
                    cnt_nx   = '0;
                    state_nx = DROP;
                end
            end
            DROP: begin
                if (valid_in) begin
                    drop_nx = 1'b1;
                end else begin
                    state_nx = WAIT;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase

        data_nx  = '0;
        valid_nx = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (route && ch_nx == CH_W'(i)) begin
                data_nx[i*DATA_W +: DATA_W] = data_in;
                valid_nx[i]                 = 1'b1;
            end
        end
    end

    always_ff @(posedge clk2f) begin
        if (!reset) begin
            state     <= IDLE;
            burst_cnt <= '0;
            cur_ch    <= '0;
            data_out  <= '0;
            valid_out <= '0;
            drop      <= 1'b0;
        end else begin
            state     <= state_nx;
            burst_cnt <= cnt_nx;
            cur_ch    <= ch_nx;
            data_out  <= data_nx;
            valid_out <= valid_nx;
            drop      <= drop_nx;
        end
    end

`ifdef DEMUX_RR_WORDCNT_EN
    always_ff @(posedge clk2f) begin
        if (!reset) begin
            words_routed <= '0;
        end else if (route && words_routed != '1) begin
            words_routed <= words_routed + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_demux_rr_n.sv
// Bench for demux_rr_n: two instances (MAX_BURST=4 and unlimited) driven in lockstep against a burst-level model.
module tb_demux_rr_n;

    logic        clk2f = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  data_in = '0;
    logic        valid_in = 1'b0;
    logic [3:0]  chan_en = '0;

    logic [31:0] dout_a, dout_b;
    logic [3:0]  vout_a, vout_b;
    logic [1:0]  cur_a, cur_b;
    logic        drop_a, drop_b;
`ifdef DEMUX_RR_WORDCNT_EN
    logic [3:0]  wr_a, wr_b;
`endif

    int checks = 0;
    int errors = 0;
    int cyc_no = 0;

    always #5 clk2f = ~clk2f;

    demux_rr_n #(.DATA_W(8), .N_CH(4), .CH_W(2), .MAX_BURST(4), .CNT_W(4)) dut_a (
        .clk2f(clk2f), .reset(reset), .data_in(data_in), .valid_in(valid_in), .chan_en(chan_en),
        .data_out(dout_a), .valid_out(vout_a), .cur_ch(cur_a), .drop(drop_a)
`ifdef DEMUX_RR_WORDCNT_EN
        , .words_routed(wr_a)
`endif
    );

    demux_rr_n #(.DATA_W(8), .N_CH(4), .CH_W(2), .MAX_BURST(0), .CNT_W(4)) dut_b (
        .clk2f(clk2f), .reset(reset), .data_in(data_in), .valid_in(valid_in), .chan_en(chan_en),
        .data_out(dout_b), .valid_out(vout_b), .cur_ch(cur_b), .drop(drop_b)
`ifdef DEMUX_RR_WORDCNT_EN
        , .words_routed(wr_b)
`endif
    );

    // Model state, index 0 tracks dut_a (limit 4), index 1 tracks dut_b (unlimited).
    int          maxb[2] = '{4, 0};
    int          m_cur[2], m_run[2], m_cnt[2];
    bit          m_fresh[2], m_inb[2], m_dropping[2];
    logic [31:0] e_data[2];
    logic [3:0]  e_valid[2];
    logic        e_drop[2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", tag, cyc_no, got, exp);
        end
    endtask

    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            e_valid[m] = '0;
            e_data[m]  = '0;
            e_drop[m]  = 1'b0;
            if (!reset) begin
                m_cur[m] = 0; m_run[m] = 0; m_cnt[m] = 0;
                m_fresh[m] = 1'b1; m_inb[m] = 1'b0; m_dropping[m] = 1'b0;
            end else if (!valid_in) begin
                m_inb[m] = 1'b0; m_dropping[m] = 1'b0; m_run[m] = 0;
            end else begin
                if (!m_inb[m] || (!m_dropping[m] && maxb[m] != 0 && m_run[m] == maxb[m])) begin
                    int  start;
                    bit  found;
                    int  ch;
                    start = m_fresh[m] ? 0 : m_cur[m] + 1;
                    found = 1'b0;
                    ch    = 0;
                    for (int k = 0; k < 4; k++) begin
                        int idx;
                        idx = (start + k) % 4;
                        if (!found && ((chan_en >> idx) & 4'd1) != 4'd0) begin
                            found = 1'b1;
                            ch    = idx;
                        end
                    end
                    m_fresh[m] = 1'b0;
                    m_inb[m]   = 1'b1;
                    if (found) begin
                        m_cur[m] = ch; m_run[m] = 0; m_dropping[m] = 1'b0;
                    end else begin
                        m_dropping[m] = 1'b1;
                    end
                end
                if (m_dropping[m]) begin
                    e_drop[m] = 1'b1;
                end else begin
                    m_run[m]++;
                    e_valid[m] = 4'd1 << m_cur[m];
                    e_data[m]  = 32'(data_in) << (8 * m_cur[m]);
                    if (m_cnt[m] != 15) m_cnt[m]++;
                end
            end
        end
    endtask

    task automatic compare();
        check("A valid_out", 64'(vout_a), 64'(e_valid[0]));
        check("A data_out",  64'(dout_a), 64'(e_data[0]));
        check("A cur_ch",    64'(cur_a),  64'(m_cur[0]));
        check("A drop",      64'(drop_a), 64'(e_drop[0]));
        check("B valid_out", 64'(vout_b), 64'(e_valid[1]));
        check("B data_out",  64'(dout_b), 64'(e_data[1]));
        check("B cur_ch",    64'(cur_b),  64'(m_cur[1]));
        check("B drop",      64'(drop_b), 64'(e_drop[1]));
`ifdef DEMUX_RR_WORDCNT_EN
        check("A words_routed", 64'(wr_a), 64'(m_cnt[0]));
        check("B words_routed", 64'(wr_b), 64'(m_cnt[1]));
`endif
    endtask

    task automatic cyc(input logic v, input logic [7:0] d);
        valid_in = v;
        data_in  = d;
        model_step();
        @(posedge clk2f);
        #1;
        cyc_no++;
        compare();
    endtask

    initial begin
        // Reset state
        reset = 1'b0;
        cyc(1'b1, 8'hEE);
        cyc(1'b0, 8'h00);
        reset = 1'b1;

        // Basic rotation
        chan_en = 4'b1111;
        cyc(1, 8'h11); cyc(1, 8'h12); cyc(1, 8'h13); cyc(0, 0);
        cyc(1, 8'h21); cyc(1, 8'h22); cyc(0, 0);
        cyc(1, 8'h31); cyc(0, 0);
        check("rotation cur_ch", 64'(cur_b), 64'd2);

        // Mask skip, then mid-burst mask change
        chan_en = 4'b1010;
        cyc(1, 8'hA0); cyc(0, 0);
        cyc(1, 8'hA1); cyc(0, 0);
        cyc(1, 8'hA2); cyc(0, 0);
        cyc(1, 8'hB0);
        chan_en = 4'b0100;
        cyc(1, 8'hB1); cyc(0, 0);
        cyc(1, 8'hB2); cyc(0, 0);
        check("mask change next burst ch2", 64'(cur_b), 64'd2);

        // Forced split on dut_a
        chan_en = 4'b1111;
        for (int i = 0; i < 10; i++) cyc(1, 8'(i));
        cyc(0, 0);

        // Drop, then recovery on ch0
        chan_en = 4'b0000;
        cyc(1, 8'hD0); cyc(1, 8'hD1); cyc(1, 8'hD2); cyc(0, 0);
        chan_en = 4'b0001;
        cyc(1, 8'h55); cyc(0, 0);

        // Reset mid-burst on ch2
        chan_en = 4'b0101;
        cyc(1, 8'h61);
        reset = 1'b0;
        cyc(1, 8'h62);
        reset = 1'b1;
        check("reset mid-burst cur_ch", 64'(cur_a), 64'd0);
        cyc(0, 0);
        cyc(1, 8'h63); cyc(0, 0);

        // Long burst for counter saturation, then dropped words
        chan_en = 4'b1111;
        for (int i = 0; i < 20; i++) cyc(1, 8'(8'h80 + i));
        cyc(0, 0);
        chan_en = 4'b0000;
        cyc(1, 8'hF0); cyc(1, 8'hF1); cyc(0, 0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) chan_en = 4'($urandom);
            reset = ($urandom_range(0, 99) != 0);
            cyc($urandom_range(0, 9) < 7, 8'($urandom));
        end
        reset = 1'b1;
        cyc(0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
